// File: rtl/mesh_gnrtr.sv
// mesh_gnrtr: mesh-edge packet generator/router model with N = 2*(ROWS+COLUMS) terminals.
// Ports: clk, reset (async active-low), source side data_out_i_in/pndng_i_in/popin, sink side data_out/pndng/pop.
module mesh_gnrtr #(
  parameter int         ROWS       = 4,
  parameter int         COLUMS     = 4,
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 16,
  parameter logic [7:0] broadcast  = 8'hFF,
  localparam int        N          = 2 * (ROWS + COLUMS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0][pckg_sz-1:0] data_out_i_in,
  input  logic [N-1:0]              pndng_i_in,
  output logic [N-1:0]              popin,
  output logic [N-1:0][pckg_sz-1:0] data_out,
  output logic [N-1:0]              pndng,
  input  logic [N-1:0]              pop
);

  localparam int RW = $clog2(N);
  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = $clog2(fifo_depth + 1);
  localparam logic [CW-1:0] FULL = CW'(fifo_depth);
  localparam logic [PW-1:0] LAST = PW'(fifo_depth - 1);

  logic [RW-1:0]              rr_q, rr_d;
  logic                       run_q;
  logic [N-1:0]               popd_q, popd_d;
  logic [N-1:0]               grant, claim, busy;
  logic [N-1:0]               s1_vld_q, s1_vld_d;
  logic [N-1:0][pckg_sz-1:0]  s1_pkt_q, s1_pkt_d;
  logic [CW-1:0]              cnt_q [N];
  logic [CW-1:0]              cnt_d [N];
  logic [PW-1:0]              wp_q [N];
  logic [PW-1:0]              wp_d [N];
  logic [PW-1:0]              rp_q [N];
  logic [PW-1:0]              rp_d [N];
  logic [N-1:0]               wr_en, rd_en;
  logic [pckg_sz-1:0]         mem_q [N][fifo_depth];

  function automatic logic [7:0] term_addr(input int t);
    logic [3:0] r;
    logic [3:0] c;
    if (t < COLUMS) begin
      r = 4'd0;
      c = 4'(t + 1);
    end else if (t < COLUMS + ROWS) begin
      r = 4'(t - COLUMS + 1);
      c = 4'd0;
    end else if (t < 2 * COLUMS + ROWS) begin
      r = 4'(ROWS + 1);
      c = 4'(t - COLUMS - ROWS + 1);
    end else begin
      r = 4'(t - 2 * COLUMS - ROWS + 1);
      c = 4'(COLUMS + 1);
    end
    return {r, c};
  endfunction

  function automatic logic [N-1:0] dst_mask(
    input logic [7:0]    a,
    input logic [RW-1:0] src
  );
    logic [N-1:0] m;
    m = '0;
    if (a == broadcast) begin
      m      = '1;
      m[src] = 1'b0;
    end else begin
      for (int t = 0; t < N; t++)
        m[t] = (term_addr(t) == a);
    end
    return m;
  endfunction

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // A destination is busy if its FIFO plus the packet already
  // staged for it would leave no room for another one.
  always_comb begin
    busy = '0;
    for (int d = 0; d < N; d++)
      busy[d] = ({1'b0, cnt_q[d]} + (CW + 1)'(s1_vld_q[d]))
                >= {1'b0, FULL};
  end

  // Round-robin scan; every grant claims its destinations so
  // later sources in the scan cannot write the same FIFO.
  always_comb begin
    int            idx;
    logic [RW-1:0] ix;
    logic [N-1:0]  tm;
    grant    = '0;
    claim    = '0;
    rr_d     = rr_q;
    s1_pkt_d = s1_pkt_q;
    idx      = 0;
    ix       = '0;
    tm       = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N) idx = idx - N;
      ix = RW'(idx);
      tm = dst_mask(data_out_i_in[ix][pckg_sz-9 -: 8], ix);
      if (run_q && pndng_i_in[ix] && !popd_q[ix] &&
          ((tm & (claim | busy)) == '0)) begin
        grant[ix] = 1'b1;
        claim     = claim | tm;
        rr_d      = (ix == RW'(N - 1)) ? '0 : ix + 1'b1;
        for (int d = 0; d < N; d++)
          if (tm[d]) s1_pkt_d[d] = data_out_i_in[ix];
      end
    end
    s1_vld_d = claim;
    popd_d   = grant;
  end

  assign popin = grant;

  always_comb begin
    wr_en    = '0;
    rd_en    = '0;
    pndng    = '0;
    data_out = '0;
    for (int d = 0; d < N; d++) begin
      cnt_d[d] = cnt_q[d];
      wp_d[d]  = wp_q[d];
      rp_d[d]  = rp_q[d];
      pndng[d] = (cnt_q[d] != '0);
      if (pndng[d]) data_out[d] = mem_q[d][rp_q[d]];
      rd_en[d] = pop[d] && pndng[d];
      wr_en[d] = s1_vld_q[d] && ((cnt_q[d] != FULL) || rd_en[d]);
      if (wr_en[d]) wp_d[d] = nxt(wp_q[d]);
      if (rd_en[d]) rp_d[d] = nxt(rp_q[d]);
      if (wr_en[d] && !rd_en[d])
        cnt_d[d] = cnt_q[d] + 1'b1;
      else if (!wr_en[d] && rd_en[d])
        cnt_d[d] = cnt_q[d] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q     <= '0;
      run_q    <= 1'b0;
      popd_q   <= '0;
      s1_vld_q <= '0;
      s1_pkt_q <= '0;
      for (int d = 0; d < N; d++) begin
        cnt_q[d] <= '0;
        wp_q[d]  <= '0;
        rp_q[d]  <= '0;
      end
    end else begin
      rr_q     <= rr_d;
      run_q    <= 1'b1;
      popd_q   <= popd_d;
      s1_vld_q <= s1_vld_d;
      s1_pkt_q <= s1_pkt_d;
      for (int d = 0; d < N; d++) begin
        cnt_q[d] <= cnt_d[d];
        wp_q[d]  <= wp_d[d];
        rp_q[d]  <= rp_d[d];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < N; d++)
      if (wr_en[d]) mem_q[d][wp_q[d]] <= s1_pkt_q[d];
  end

endmodule

// File: tb/tb_mesh_gnrtr.sv
// tb_mesh_gnrtr: directed and random checks of mesh_gnrtr against a
// per-(source,destination) ordered scoreboard.
module tb_mesh_gnrtr;

  localparam int TR = 4;
  localparam int TC = 4;
  localparam int P  = 40;
  localparam int N  = 2 * (TR + TC);

  logic                clk;
  logic                reset;
  logic [N-1:0][P-1:0] data_out_i_in;
  logic [N-1:0]        pndng_i_in;
  logic [N-1:0]        popin;
  logic [N-1:0][P-1:0] data_out;
  logic [N-1:0]        pndng;
  logic [N-1:0]        pop;

  mesh_gnrtr #(
    .ROWS(TR), .COLUMS(TC), .pckg_sz(P),
    .fifo_depth(16), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset),
    .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in),
    .popin(popin), .data_out(data_out),
    .pndng(pndng), .pop(pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  logic [P-1:0] src_q [N][$];
  logic [P-1:0] expq  [N][N][$];
  int           glog  [$];
  int           grant_cnt [N];
  int           gcyc [N];
  int           rise_cyc [N];
  logic [N-1:0] prev_gr;
  logic [N-1:0] prev_pndng;
  logic [N-1:0] pop_mask;
  int           cyc;
  int           delivered;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int term_of(input int r, input int c);
    if (r == 0 && c >= 1 && c <= TC) return c - 1;
    if (c == 0 && r >= 1 && r <= TR) return TC + r - 1;
    if (r == TR + 1 && c >= 1 && c <= TC) return TC + TR + c - 1;
    if (c == TC + 1 && r >= 1 && r <= TR) return 2 * TC + TR + r - 1;
    return -1;
  endfunction

  function automatic logic [P-1:0] mk(input int r, input int c,
                                      input bit m,
                                      input logic [P-18:0] pl);
    return {8'($urandom), 4'(r), 4'(c), m, pl};
  endfunction

  function automatic logic [P-1:0] rand_pkt();
    int k, t, rr, cc;
    k = $urandom_range(0, 19);
    if (k == 0) return mk(15, 15, 1'($urandom), (P-17)'($urandom));
    if (k == 1) return mk(7, 7, 1'($urandom), (P-17)'($urandom));
    if (k == 2) return mk(0, 0, 1'($urandom), (P-17)'($urandom));
    t  = $urandom_range(0, N - 1);
    rr = 0;
    cc = 0;
    for (int r = 0; r <= TR + 1; r++)
      for (int c = 0; c <= TC + 1; c++)
        if (term_of(r, c) == t) begin
          rr = r;
          cc = c;
        end
    return mk(rr, cc, 1'($urandom), (P-17)'($urandom));
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pndng_i_in[i]    = (src_q[i].size() > 0);
      data_out_i_in[i] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic on_grant(input int i);
    logic [P-1:0] p;
    int t;
    p = src_q[i][0];
    void'(src_q[i].pop_front());
    if (p[P-9 -: 8] == 8'hFF) begin
      for (int d = 0; d < N; d++)
        if (d != i) expq[i][d].push_back(p);
    end else begin
      t = term_of(int'(p[P-9 -: 4]), int'(p[P-13 -: 4]));
      if (t >= 0) expq[i][t].push_back(p);
    end
  endtask

  task automatic on_deliver(input int d, input logic [P-1:0] p);
    bit found;
    found = 1'b0;
    for (int s = 0; s < N; s++)
      if (!found && expq[s][d].size() > 0 && expq[s][d][0] == p) begin
        void'(expq[s][d].pop_front());
        found = 1'b1;
      end
    delivered++;
    chk($sformatf("deliver_t%0d", d), 64'(found), 64'd1);
  endtask

  task automatic cycle(input bit rnd);
    logic [N-1:0] gr;
    @(negedge clk);
    cyc++;
    gr = popin;
    for (int i = 0; i < N; i++)
      if (gr[i]) begin
        chk("popin_pend", 64'(pndng_i_in[i]), 64'd1);
        chk("popin_consec", 64'(prev_gr[i]), 64'd0);
        grant_cnt[i]++;
        gcyc[i] = cyc;
        glog.push_back(i);
      end
    for (int d = 0; d < N; d++)
      if (pndng[d] && !prev_pndng[d]) rise_cyc[d] = cyc;
    prev_pndng = pndng;
    prev_gr    = gr;
    pop = rnd ? N'($urandom) : pop_mask;
    for (int d = 0; d < N; d++)
      if (pop[d] && pndng[d]) on_deliver(d, data_out[d]);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (gr[i]) on_grant(i);
    drive();
  endtask

  task automatic clear_model();
    for (int s = 0; s < N; s++) begin
      src_q[s].delete();
      for (int d = 0; d < N; d++) expq[s][d].delete();
    end
    prev_gr = '0;
    drive();
  endtask

  task automatic drain(input string tag);
    int quiet, left;
    bit empty;
    quiet    = 0;
    pop_mask = '1;
    for (int k = 0; k < 3000 && quiet < 4; k++) begin
      cycle(0);
      empty = 1'b1;
      for (int s = 0; s < N; s++)
        if (src_q[s].size() > 0) empty = 1'b0;
      if (pndng == '0 && empty) quiet++;
      else quiet = 0;
    end
    pop_mask = '0;
    left = 0;
    for (int s = 0; s < N; s++) begin
      left += src_q[s].size();
      for (int d = 0; d < N; d++) left += expq[s][d].size();
    end
    chk({tag, "_left"}, 64'(left), 64'd0);
  endtask

  initial begin
    logic [P-1:0] pk;
    int base, dbase, s;
    reset         = 1'b0;
    pop           = '0;
    pop_mask      = '0;
    pndng_i_in    = '0;
    data_out_i_in = '0;
    prev_gr       = '0;
    prev_pndng    = '0;
    cyc           = 0;
    delivered     = 0;
    for (int i = 0; i < N; i++) begin
      grant_cnt[i] = 0;
      gcyc[i]      = 0;
      rise_cyc[i]  = -100;
    end
    #3;
    chk("rst_pndng", 64'(pndng), 64'd0);
    chk("rst_popin", 64'(popin), 64'd0);
    chk("rst_dout", 64'(|data_out), 64'd0);
    repeat (2) cycle(0);
    reset = 1'b1;

    // unicast 0 -> row 2 col 0 (terminal 5)
    base = grant_cnt[0];
    pk   = mk(2, 0, 1'b1, (P-17)'(16'hA5A5));
    src_q[0].push_back(pk);
    drive();
    repeat (6) cycle(0);
    chk("uni_grants", 64'(grant_cnt[0] - base), 64'd1);
    chk("uni_lat", 64'(rise_cyc[5] - gcyc[0]), 64'd2);
    chk("uni_mask", 64'(pndng), 64'h20);
    chk("uni_data", 64'(data_out[5]), 64'(pk));
    drain("uni");

    // broadcast from terminal 3
    base = grant_cnt[3];
    src_q[3].push_back(mk(15, 15, 1'b0, (P-17)'($urandom)));
    drive();
    repeat (6) cycle(0);
    chk("bc_grants", 64'(grant_cnt[3] - base), 64'd1);
    chk("bc_mask", 64'(pndng), 64'hFFF7);
    drain("bc");

    // backpressure 4 -> 12 (row 1 col 5)
    base = grant_cnt[4];
    for (int k = 0; k < 17; k++)
      src_q[4].push_back(mk(1, TC + 1, 1'($urandom), (P-17)'($urandom)));
    drive();
    repeat (45) cycle(0);
    chk("bp_grants", 64'(grant_cnt[4] - base), 64'd16);
    chk("bp_src_left", 64'(src_q[4].size()), 64'd1);
    chk("bp_pndng", 64'(pndng[12]), 64'd1);
    pop_mask = N'(1) << 12;
    cycle(0);
    pop_mask = '0;
    repeat (6) cycle(0);
    chk("bp_grants2", 64'(grant_cnt[4] - base), 64'd17);
    drain("bp");

    // contention 0,1,2 -> 10 (row 5 col 3), pointer reset to 0
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++)
      src_q[i].push_back(mk(TR + 1, 3, 1'($urandom), (P-17)'($urandom)));
    drive();
    repeat (2) cycle(0);
    glog.delete();
    reset = 1'b1;
    #1;
    chk("rel_popin", 64'(popin), 64'd0);
    repeat (8) cycle(0);
    chk("ct_count", 64'(glog.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("ct_order%0d", k),
          64'((glog.size() > k) ? glog[k] : -1), 64'(k));
    drain("ct");

    // invalid address from terminal 8
    base = grant_cnt[8];
    src_q[8].push_back(mk(7, 7, 1'b1, (P-17)'($urandom)));
    drive();
    repeat (6) cycle(0);
    chk("inv_grants", 64'(grant_cnt[8] - base), 64'd1);
    chk("inv_pndng", 64'(pndng), 64'd0);

    // reset with traffic queued and in flight
    src_q[5].push_back(mk(0, 1, 1'b0, (P-17)'($urandom)));
    src_q[6].push_back(mk(0, 2, 1'b1, (P-17)'($urandom)));
    src_q[7].push_back(mk(2, TC + 1, 1'b0, (P-17)'($urandom)));
    src_q[9].push_back(mk(0, 3, 1'b1, (P-17)'($urandom)));
    src_q[11].push_back(mk(4, TC + 1, 1'b0, (P-17)'($urandom)));
    drive();
    repeat (3) cycle(0);
    chk("mid_pre", 64'(pndng != '0), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_pndng", 64'(pndng), 64'd0);
    chk("mid_dout", 64'(|data_out), 64'd0);
    chk("mid_popin", 64'(popin), 64'd0);
    clear_model();
    repeat (3) cycle(0);
    reset    = 1'b1;
    dbase    = delivered;
    pop_mask = '1;
    repeat (10) cycle(0);
    pop_mask = '0;
    chk("mid_deliv", 64'(delivered - dbase), 64'd0);
    chk("mid_post", 64'(pndng), 64'd0);

    // random traffic
    repeat (1500) begin
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, N - 1);
        if (src_q[s].size() < 4) src_q[s].push_back(rand_pkt());
      end
      drive();
      cycle(1);
    end
    drain("rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
